pin_io_ring: RTL and testbench
==============================

Name: pin_io_ring

Overview:
- Parametrised pad-side I/O conditioner between raw bidirectional pads and the core's pin_in/pin_out/pin_dir buses.
- Replaces the flat single-register input capture and per-pin tristate assigns.
- Adds a multi-stage input synchroniser and a per-pin glitch filter.
- Adds sticky rise/fall event flags, per-pin open-drain mode and registered output enables.
- Instantiated once per I/O bank at top level; the top-level wrapper ties pad_out/pad_oe to the inout pins.

Parameters:
- WIDTH, 32, number of pins handled.
- SYNC_STAGES, 2, synchroniser flops per pin; legal values ≥2.
- FILT_LEN, 4, consecutive stable cycles required before the filtered value changes; legal values ≥1. Counter width is clog2(FILT_LEN)+1.

Ports:
- clk_cog  in  1  single clock; all state clocked on rising edge.
- nres  in  1  asynchronous active-low reset.
- pad_in  in  WIDTH  raw asynchronous pad levels.
- pin_out  in  WIDTH  core output data.
- pin_dir  in  WIDTH  core direction, 1 = drive.
- od_mode  in  WIDTH  per-pin open-drain enable.
- filt_en  in  WIDTH  per-pin glitch-filter enable.
- evt_clr  in  WIDTH  per-pin clear of rise/fall flags.
- pad_out  out  WIDTH  registered pad drive value.
- pad_oe  out  WIDTH  registered pad output enable.
- pin_in  out  WIDTH  synchronised, filtered input to the core.
- rise  out  WIDTH  sticky rising-edge flags.
- fall  out  WIDTH  sticky falling-edge flags.
- evt_any  out  1  OR of all rise and fall bits.

Behaviour:
- Reset (nres=0, asynchronous): all of the following clear to 0 — sync chains, filter counters, pin_in, rise, fall, pad_out, pad_oe, arm counter. evt_any therefore reads 0.
- Synchroniser: each pin is a SYNC_STAGES-deep shift chain from pad_in; s[i] denotes the last stage.
- Arm window:
  - An arm counter runs for SYNC_STAGES+1 cycles after nres deasserts.
  - While it runs, pin_in <= s every cycle regardless of filt_en, filter counters are held at 0, and rise/fall never set.
  - Purpose: prevents false edges from pads already high at reset release.
  - Once armed, it stays armed until the next reset.
- Filter, per pin, after arming:
  - filt_en=0: pin_in[i] <= s[i] each cycle; counter held at 0.
  - filt_en=1 and s[i]==pin_in[i]: counter <= 0.
  - filt_en=1 and s[i]!=pin_in[i] with counter < FILT_LEN-1: counter increments.
  - filt_en=1 and s[i]!=pin_in[i] with counter == FILT_LEN-1: pin_in[i] <= s[i] and counter <= 0.
  - Net effect: a change must persist FILT_LEN consecutive cycles. A single disagreeing cycle restarts the count.
  - Toggling filt_en mid-count: counter resets to 0 on the first cycle filt_en=0.
- Input latency, pad change to pin_in:
  - Unfiltered: SYNC_STAGES+1 cycles.
  - Filtered: SYNC_STAGES+FILT_LEN cycles.
  - FILT_LEN=1 gives identical timing for both.
- Edge flags:
  - rise[i] sets on the same edge that pin_in[i] goes 0→1; fall[i] sets on the same edge that it goes 1→0. The new pin_in and the flag become visible together.
  - Flags hold until evt_clr[i] is sampled high.
  - A set and a clear on the same edge: set wins, so no event is lost.
  - evt_any is combinational OR of the rise and fall registers.
- Output path, registered with one cycle latency from pin_out/pin_dir/od_mode:
  - pad_out <= pin_out.
  - pad_oe <= pin_dir & (~od_mode | ~pin_out).
  - Open-drain pins drive only low; otherwise they float.
- Independence: pins are fully independent; no cross-pin interaction except evt_any.
- Reset mid-operation: everything clears immediately, including mid-filter-count. The arm window restarts on release.

Test Plan:
- Reset release with pad_in=0xFFFF_FFFF → pin_in=0xFFFF_FFFF exactly SYNC_STAGES+1 cycles after nres rises; rise=fall=0, evt_any=0.
- Armed, filt_en=0, pad_in[3] 0→1 → pin_in[3]=1 and rise[3]=1 three cycles later (defaults); evt_clr[3] pulse clears rise[3] next edge.
- filt_en[5]=1, 3-cycle pulse on pad_in[5] → pin_in[5] unchanged, no flag. A 4-cycle pulse → pin_in[5]=1 after 6 cycles, then fall[5] when it drops.
- evt_clr[7]=1 held on the edge a new rise[7] event arrives → rise[7]=1 afterwards.
- pin_dir=1, od_mode=1: pin_out=0 → pad_oe=1, pad_out=0 next cycle. pin_out=1 → pad_oe=0. With od_mode=0, pad_oe=1 for both values.
- nres asserted mid-filter-count on pin 9 → all outputs 0 asynchronously. After release, the arm window repeats with no spurious flags.

Source files
------------

// File: rtl/pin_io_ring_if.sv
// pin_io_ring_if: pad- and core-side buses of one I/O bank.
// master = core/bench side driving inputs, slave = the ring itself.
interface pin_io_ring_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] pin_out;
  logic [WIDTH-1:0] pin_dir;
  logic [WIDTH-1:0] od_mode;
  logic [WIDTH-1:0] filt_en;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] pad_out;
  logic [WIDTH-1:0] pad_oe;
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             evt_any;

  modport master (
    output pad_in,
    output pin_out,
    output pin_dir,
    output od_mode,
    output filt_en,
    output evt_clr,
    input  pad_out,
    input  pad_oe,
    input  pin_in,
    input  rise,
    input  fall,
    input  evt_any
  );

  modport slave (
    input  pad_in,
    input  pin_out,
    input  pin_dir,
    input  od_mode,
    input  filt_en,
    input  evt_clr,
    output pad_out,
    output pad_oe,
    output pin_in,
    output rise,
    output fall,
    output evt_any
  );
endinterface

// File: rtl/pin_io_ring.sv
// pin_io_ring: pad-side conditioner (sync, glitch filter, edge flags, oe).
// Ports: clk_cog, nres (async low), io (pin_io_ring_if.slave bus).
module pin_io_ring #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input logic         clk_cog,
  input logic         nres,
  pin_io_ring_if.slave io
);

  localparam int CW = $clog2(FILT_LEN) + 1;
  localparam int AW = $clog2(SYNC_STAGES + 2);

  localparam logic [AW-1:0] ARM_END = AW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(FILT_LEN - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [AW-1:0]    arm_cnt;
  logic             armed;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  logic [WIDTH-1:0] pin_q;
  logic [WIDTH-1:0] pin_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] pad_out_q;
  logic [WIDTH-1:0] pad_oe_q;

  logic [WIDTH-1:0] hold_v;
  logic [WIDTH-1:0] same_v;
  logic [WIDTH-1:0] top_v;

  assign s     = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_END);

  // Pins pass straight through while unarmed or unfiltered.
  assign hold_v = ~io.filt_en | {WIDTH{~armed}};
  assign same_v = ~(s ^ pin_q);

  always_comb begin
    top_v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      top_v[i] = (cnt_q[i] == CNT_TOP);
    end
  end

  always_comb begin
    pin_d = pin_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      unique case (1'b1)
        hold_v[i]: begin
          pin_d[i] = s[i];
        end
        !hold_v[i] && same_v[i]: begin
          cnt_d[i] = '0;
        end
        !hold_v[i] && !same_v[i] && top_v[i]: begin
          pin_d[i] = s[i];
        end
        !hold_v[i] && !same_v[i] && !top_v[i]: begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
        default: begin
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Set beats clear so an edge landing on a clear is kept.
  always_comb begin
    rise_d = rise_q & ~io.evt_clr;
    fall_d = fall_q & ~io.evt_clr;
    if (armed) begin
      rise_d = rise_d | (pin_d & ~pin_q);
      fall_d = fall_d | (~pin_d & pin_q);
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= io.pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      pin_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pin_q  <= pin_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Open-drain pins only enable the driver when pulling low.
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      pad_out_q <= io.pin_out;
      pad_oe_q  <= io.pin_dir & (~io.od_mode | ~io.pin_out);
    end
  end

  assign io.pad_out = pad_out_q;
  assign io.pad_oe  = pad_oe_q;
  assign io.pin_in  = pin_q;
  assign io.rise    = rise_q;
  assign io.fall    = fall_q;
  assign io.evt_any = |{rise_q, fall_q};

endmodule

// File: tb/tb_pin_io_ring.sv
// tb_pin_io_ring: directed bench with a cycle-stamped expectation queue.
// Checks sync latency, filter, flags, output enables and async reset.
module tb_pin_io_ring;

  localparam int SEL_PIN  = 0;
  localparam int SEL_RISE = 1;
  localparam int SEL_FALL = 2;
  localparam int SEL_OE   = 3;
  localparam int SEL_OUT  = 4;
  localparam int SEL_EVT  = 5;

  typedef struct {
    int          cyc;
    string       tag;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic nres;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  pin_io_ring_if #(.WIDTH(32)) io ();

  pin_io_ring #(
    .WIDTH(32),
    .SYNC_STAGES(2),
    .FILT_LEN(4)
  ) dut (
    .clk_cog(clk),
    .nres(nres),
    .io(io.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] observe(int sel);
    case (sel)
      SEL_PIN:  return io.pin_in;
      SEL_RISE: return io.rise;
      SEL_FALL: return io.fall;
      SEL_OE:   return io.pad_oe;
      SEL_OUT:  return io.pad_out;
      default:  return {31'b0, io.evt_any};
    endcase
  endfunction

  task automatic expect_at(int d, string tag, int sel,
                           logic [31:0] mask, logic [31:0] e);
    exp_t x;
    x.cyc  = cyc + d;
    x.tag  = tag;
    x.sel  = sel;
    x.mask = mask;
    x.exp  = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (sb[k]) begin
      if (sb[k].cyc == cyc) begin
        chk(sb[k].tag, observe(sb[k].sel) & sb[k].mask,
            sb[k].exp & sb[k].mask);
      end else begin
        keep.push_back(sb[k]);
      end
    end
    sb = keep;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  localparam logic [31:0] B3 = 32'h0000_0008;
  localparam logic [31:0] B5 = 32'h0000_0020;
  localparam logic [31:0] B7 = 32'h0000_0080;
  localparam logic [31:0] AL = 32'hFFFF_FFFF;
  localparam logic [31:0] E1 = 32'h0000_0001;

  initial begin
    checks     = 0;
    errors     = 0;
    nres       = 1'b0;
    io.pad_in  = AL;
    io.pin_out = '0;
    io.pin_dir = '0;
    io.od_mode = '0;
    io.filt_en = '0;
    io.evt_clr = '0;
    tick(3);

    chk("rst_pin_in", io.pin_in, '0);
    chk("rst_rise", io.rise, '0);
    chk("rst_fall", io.fall, '0);
    chk("rst_pad_oe", io.pad_oe, '0);
    chk("rst_pad_out", io.pad_out, '0);
    chk("rst_evt_any", {31'b0, io.evt_any}, '0);

    nres = 1'b1;
    expect_at(2, "arm_pin_early", SEL_PIN, AL, '0);
    expect_at(3, "arm_pin_in", SEL_PIN, AL, AL);
    expect_at(3, "arm_rise", SEL_RISE, AL, '0);
    expect_at(5, "arm_rise_late", SEL_RISE, AL, '0);
    expect_at(5, "arm_fall", SEL_FALL, AL, '0);
    expect_at(5, "arm_evt", SEL_EVT, E1, '0);
    tick(6);

    io.pad_in = '0;
    expect_at(2, "drop_pin_early", SEL_PIN, AL, AL);
    expect_at(3, "drop_pin", SEL_PIN, AL, '0);
    expect_at(3, "drop_fall", SEL_FALL, AL, AL);
    tick(3);
    io.evt_clr = AL;
    expect_at(1, "clr_all_fall", SEL_FALL, AL, '0);
    tick(1);
    io.evt_clr = '0;
    io.filt_en = B5;
    tick(2);

    io.pad_in[3] = 1'b1;
    expect_at(2, "p3_pin_early", SEL_PIN, B3, '0);
    expect_at(3, "p3_pin", SEL_PIN, B3, B3);
    expect_at(3, "p3_rise", SEL_RISE, AL, B3);
    expect_at(3, "p3_evt", SEL_EVT, E1, E1);
    tick(3);
    io.evt_clr[3] = 1'b1;
    expect_at(1, "p3_rise_clr", SEL_RISE, AL, '0);
    expect_at(1, "p3_evt_clr", SEL_EVT, E1, '0);
    tick(1);
    io.evt_clr = '0;
    tick(2);

    io.pad_in[5] = 1'b1;
    for (int d = 4; d <= 8; d++) begin
      expect_at(d, "p5_short_pin", SEL_PIN, B5, '0);
    end
    expect_at(8, "p5_short_rise", SEL_RISE, B5, '0);
    tick(3);
    io.pad_in[5] = 1'b0;
    tick(8);

    io.pad_in[5] = 1'b1;
    expect_at(5, "p5_long_early", SEL_PIN, B5, '0);
    expect_at(6, "p5_long_pin", SEL_PIN, B5, B5);
    expect_at(6, "p5_long_rise", SEL_RISE, B5, B5);
    expect_at(9, "p5_hold_pin", SEL_PIN, B5, B5);
    expect_at(10, "p5_drop_pin", SEL_PIN, B5, '0);
    expect_at(10, "p5_fall", SEL_FALL, B5, B5);
    tick(4);
    io.pad_in[5] = 1'b0;
    tick(8);

    io.pad_in[7]  = 1'b1;
    io.evt_clr[7] = 1'b1;
    expect_at(3, "p7_set_wins", SEL_RISE, B7, B7);
    expect_at(5, "p7_kept", SEL_RISE, B7, B7);
    tick(3);
    io.evt_clr[7] = 1'b0;
    tick(4);

    io.pin_dir = AL;
    io.od_mode = 32'hFFFF_0000;
    io.pin_out = '0;
    expect_at(0, "oe_latency", SEL_OE, AL, '0);
    expect_at(1, "oe_low", SEL_OE, AL, AL);
    expect_at(1, "out_low", SEL_OUT, AL, '0);
    tick(1);
    io.pin_out = AL;
    expect_at(1, "oe_high", SEL_OE, AL, 32'h0000_FFFF);
    expect_at(1, "out_high", SEL_OUT, AL, AL);
    tick(1);
    io.pin_dir = 32'h0F0F_0F0F;
    io.pin_out = 32'h00FF_00FF;
    expect_at(1, "oe_mix", SEL_OE, AL, 32'h0F00_0F0F);
    expect_at(1, "out_mix", SEL_OUT, AL, 32'h00FF_00FF);
    tick(2);

    io.filt_en[9] = 1'b1;
    io.pad_in[9]  = 1'b1;
    tick(4);
    #1;
    nres = 1'b0;
    #1;
    chk("mid_rst_pin_in", io.pin_in, '0);
    chk("mid_rst_rise", io.rise, '0);
    chk("mid_rst_fall", io.fall, '0);
    chk("mid_rst_pad_oe", io.pad_oe, '0);
    chk("mid_rst_pad_out", io.pad_out, '0);
    chk("mid_rst_evt", {31'b0, io.evt_any}, '0);
    tick(2);

    nres = 1'b1;
    expect_at(2, "rearm_pin_early", SEL_PIN, AL, '0);
    expect_at(3, "rearm_pin", SEL_PIN, AL, 32'h0000_0288);
    expect_at(3, "rearm_rise", SEL_RISE, AL, '0);
    expect_at(3, "rearm_fall", SEL_FALL, AL, '0);
    expect_at(6, "rearm_pin_late", SEL_PIN, AL, 32'h0000_0288);
    expect_at(6, "rearm_rise_late", SEL_RISE, AL, '0);
    expect_at(6, "rearm_fall_late", SEL_FALL, AL, '0);
    expect_at(6, "rearm_evt", SEL_EVT, E1, '0);
    tick(8);

    for (int w = 0; w < 50 && sb.size() != 0; w++) begin
      tick(1);
    end
    if (sb.size() != 0) begin
      chk("drain_pending", 32'(sb.size()), '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
